// File: rtl/mcycle_unit_if.sv
// Request/result bundle between the Execute stage and the multi-cycle
// multiply/divide unit.
interface mcycle_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;

    modport master (
        output Start, MCycleOp, Operand1, Operand2,
        input  Result1, Result2, Busy
    );

    modport slave (
        input  Start, MCycleOp, Operand1, Operand2,
        output Result1, Result2, Busy
    );
endinterface

// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with a sign fix-up on the last step.
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input logic          CLK,
    input logic          RESET,
    mcycle_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COMPUTING, DONE} state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state;
    logic [CW-1:0]      count;
    logic               is_div;
    logic [WIDTH-1:0]   opnd;       // multiplicand (mul) or divisor (div)
    logic [2*WIDTH-1:0] acc;        // {partial product, multiplier} or {remainder, dividend/quotient}
    logic               neg_prod;
    logic               neg_quo;
    logic               neg_rem;
    logic               div_zero;
    logic [WIDTH-1:0]   result1;
    logic [WIDTH-1:0]   result2;

    logic               in_signed;
    logic               sign1;
    logic               sign2;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign bus.Busy    = ~RESET & (((state == IDLE) & bus.Start) | (state == COMPUTING));
    assign bus.Result1 = result1;
    assign bus.Result2 = result2;

    // Operand magnitudes and result signs for the request being accepted.
    always_comb begin
        in_signed = ~bus.MCycleOp[0];
        sign1     = in_signed & bus.Operand1[WIDTH-1];
        sign2     = in_signed & bus.Operand2[WIDTH-1];
        mag1      = sign1 ? -bus.Operand1 : bus.Operand1;
        mag2      = sign2 ? -bus.Operand2 : bus.Operand2;
    end

    // One iteration of each datapath, plus the sign-corrected final results.
    always_comb begin
        // Multiply: add multiplicand into the high half when the multiplier
        // LSB is set, then shift the whole register right with the carry.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        // Divide: shift remainder:dividend left, trial-subtract the divisor.
        // The comparison is done on the full WIDTH+1 bits so a zero divisor
        // (remainder not bounded by the divisor) still behaves.
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc[WIDTH-2:0], div_ge};

        prod_fix = neg_prod ? -mul_next : mul_next;
        quo_fix  = div_zero ? '1 :
                   (neg_quo ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0]);
        rem_fix  = neg_rem ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
    end

    // Control FSM and datapath registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            count    <= '0;
            is_div   <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            neg_prod <= 1'b0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            result1  <= '0;
            result2  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        is_div   <= bus.MCycleOp[1];
                        opnd     <= bus.MCycleOp[1] ? mag2 : mag1;
                        acc      <= {{WIDTH{1'b0}}, (bus.MCycleOp[1] ? mag1 : mag2)};
                        neg_prod <= sign1 ^ sign2;
                        neg_quo  <= sign1 ^ sign2;
                        neg_rem  <= sign1;
                        div_zero <= (bus.Operand2 == '0);
                        count    <= '0;
                        state    <= COMPUTING;
                    end
                end
                COMPUTING: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        if (is_div) begin
                            result1 <= quo_fix;
                            result2 <= rem_fix;
                        end else begin
                            result1 <= prod_fix[WIDTH-1:0];
                            result2 <= prod_fix[2*WIDTH-1:WIDTH];
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/mcycle_unit.md
Name: mcycle_unit

Overview:
- Iterative multi-cycle multiply/divide unit in the Execute stage.
- Consumes the ID/EX register outputs MCycleOpE, MCycleStartE and the forwarded source operands.
- Produces the 2×WIDTH product, or the quotient and remainder.
- Drives Busy, which stalls the ID/EX register and the upstream stages until the result is ready.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- CLK  input  1  clock, rising-edge.
- RESET  input  1  asynchronous, active-high reset.
- Start  input  1  request for a multi-cycle operation (MCycleStartE).
- MCycleOp  input  2  00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div.
- Operand1  input  WIDTH  multiplicand or dividend.
- Operand2  input  WIDTH  multiplier or divisor.
- Result1  output  WIDTH  low product word, or quotient.
- Result2  output  WIDTH  high product word, or remainder.
- Busy  output  1  stall request to the pipeline.

Behaviour:
- Reset (async, RESET=1): state=IDLE, count=0, Result1=0, Result2=0, all internal registers cleared. Busy is forced to 0 while RESET is high.
- States: IDLE, COMPUTING, DONE.
- Busy = ~RESET & ((state==IDLE & Start) | state==COMPUTING). Busy is combinational, so the pipeline stalls in the same cycle the request arrives.
- IDLE:
  - On Start=1, latch MCycleOp.
  - Latch |Operand1| and |Operand2| for the signed ops, raw operands for the unsigned ops.
  - Record the result signs: product sign = sign1^sign2; quotient sign = sign1^sign2; remainder sign = sign1.
  - Record divide-by-zero (Operand2==0); clear count; go to COMPUTING.
  - Start=0: remain in IDLE.
- COMPUTING: exactly one iteration per cycle, WIDTH cycles, count 0..WIDTH-1.
  - Multiply: shift-add. Accumulate into a 2×WIDTH register from the multiplier LSB; shift right.
  - Divide: restoring division. Shift the remainder:dividend pair left by 1; trial-subtract the divisor; set the quotient bit when the remainder ≥ divisor.
  - On count==WIDTH-1, apply the sign fix-up and register Result1/Result2, then go to DONE.
  - Sign fix-up: two's-complement negate of the full 2×WIDTH product; separate negation of quotient and remainder.
- DONE:
  - Busy=0, so the requesting instruction advances this cycle.
  - Start is ignored in this cycle, even if still high for the same instruction; there is no restart.
  - Next state is always IDLE.
- Latency: the Start cycle plus WIDTH compute cycles gives Busy high for WIDTH+1 consecutive cycles. Results are valid from the DONE cycle onward.
- Result1/Result2 hold their values until the next operation completes. They are not cleared on entering IDLE.
- Divide by zero: uses full latency. Quotient = all ones (overrides sign fix-up). Remainder = Operand1 unchanged.
- Signed overflow (most-negative / -1): quotient = most-negative, remainder = 0. This falls out of the unsigned magnitude path; no special case is required.
- Unsigned ops: no sign fix-up.
- Operands and MCycleOp are sampled only in the Start cycle. Input changes during COMPUTING have no effect.
- RESET asserted mid-operation: immediate return to IDLE with Busy=0 and results cleared. After RESET deasserts, a held Start begins a fresh operation.
- Back-to-back operations: a new Start is accepted in the IDLE cycle directly following DONE.

Test Plan:
- Signed mul: Operand1=0xFFFFFFFD (-3), Operand2=7, MCycleOp=00.
  - Busy high 33 cycles, then low 1 cycle (DONE).
  - Result1=0xFFFFFFEB, Result2=0xFFFFFFFF.
- Unsigned mul: 0xFFFFFFFF × 0xFFFFFFFF, MCycleOp=01 → Result1=0x00000001, Result2=0xFFFFFFFE.
- Signed div: -7 / 2, MCycleOp=10 → Result1=0xFFFFFFFD, Result2=0xFFFFFFFF.
- Unsigned div: 100 / 7, MCycleOp=11 → Result1=14, Result2=2.
- Edge cases:
  - Signed -5 / 0 → Result1=0xFFFFFFFF, Result2=0xFFFFFFFB.
  - 0x80000000 / 0xFFFFFFFF signed → Result1=0x80000000, Result2=0.
  - Both with Busy high 33 cycles.
- Handshake and reset:
  - Hold Start=1 through DONE → Busy=0 in DONE and no restart; a new Start in the next cycle re-asserts Busy immediately.
  - Assert RESET at compute cycle 10 → Busy=0 at once, Result1=Result2=0, state IDLE.
  - Deassert RESET with Start=1 → a full 33-cycle operation follows.
